// File: rtl/tk1_spi_pkg.sv
// Shared definitions for the tk1 SPI master: defaults, FSM encoding, SPI mode constants.
package tk1_spi_pkg;

    localparam int TK1_SPI_DEF_DATA_WIDTH = 8;
    localparam int TK1_SPI_DEF_NUM_CS     = 1;
    localparam int TK1_SPI_DEF_DIV_WIDTH  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_TRAIL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_cfg_t;

    localparam spi_cfg_t SPI_CFG_RESET = '{cpol: 1'b0, cpha: 1'b0, lsb_first: 1'b0};

    function automatic logic [1:0] spi_mode(input spi_cfg_t cfg);
        return {cfg.cpol, cfg.cpha};
    endfunction

endpackage

// File: rtl/tk1_spi_clk_div.sv
// Half-period counter: counts 0..div and reloads; tick marks the last count of each half period.
module tk1_spi_clk_div
    import tk1_spi_pkg::*;
#(
    parameter int DIV_WIDTH = TK1_SPI_DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    assign tick = (cnt == div);

    // Restart the half period on load, otherwise wrap at div
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load || (cnt == div)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tk1_spi_master_param.sv
// Parameterised SPI master: one word per start, CPOL/CPHA/bit order/divider latched per transfer.
module tk1_spi_master_param
    import tk1_spi_pkg::*;
#(
    parameter int DATA_WIDTH = TK1_SPI_DEF_DATA_WIDTH,
    parameter int NUM_CS     = TK1_SPI_DEF_NUM_CS,
    parameter int DIV_WIDTH  = TK1_SPI_DEF_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [NUM_CS-1:0]     spi_ss,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    input  logic                  spi_enable,
    input  logic                  spi_enable_vld,
    input  logic [2:0]            spi_cs_sel,
    input  logic                  spi_cpol,
    input  logic                  spi_cpha,
    input  logic                  spi_lsb_first,
    input  logic [DIV_WIDTH-1:0]  spi_clk_div,
    input  logic                  spi_start,
    input  logic [DATA_WIDTH-1:0] spi_tx_data,
    input  logic                  spi_tx_data_vld,
    output logic [DATA_WIDTH-1:0] spi_rx_data,
    output logic                  spi_rx_vld,
    output logic                  spi_ready
);

    localparam int                EDGE_W     = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] FIRST_EDGE = EDGE_W'(1);

    logic [1:0]            state;
    spi_cfg_t              cfg;
    logic [DIV_WIDTH-1:0]  cfg_div;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [EDGE_W-1:0]     edge_num;
    logic [NUM_CS-1:0]     ss_next;
    logic                  tick;
    logic                  accept;
    logic                  lead_tick;
    logic                  trail_tick;
    logic                  first_edge;
    logic                  last_edge;
    logic                  sample_on_trail;
    logic                  shift_tx;
    logic                  sample_rx;
    logic                  mosi_lsb;

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] sr,
                                                        input logic lsb);
        return lsb ? (sr >> 1) : (sr << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                       input logic bit_in, input logic lsb);
        return lsb ? {bit_in, sr[DATA_WIDTH-1:1]} : {sr[DATA_WIDTH-2:0], bit_in};
    endfunction

    tk1_spi_clk_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .div   (cfg_div),
        .tick  (tick)
    );

    assign spi_ready  = (state == ST_IDLE);
    assign accept     = spi_start && spi_ready;
    assign lead_tick  = tick && (state == ST_LEAD);
    assign trail_tick = tick && (state == ST_TRAIL);
    assign edge_num   = edge_cnt + FIRST_EDGE;
    assign first_edge = (edge_num == FIRST_EDGE);
    assign last_edge  = (edge_num == LAST_EDGE);

    // Data is sampled on the leading edge in modes 0/2 and on the trailing edge in modes 1/3
    always_comb begin
        sample_on_trail = 1'b0;
        case (spi_mode(cfg))
            SPI_MODE1, SPI_MODE3: sample_on_trail = 1'b1;
            SPI_MODE0, SPI_MODE2: sample_on_trail = 1'b0;
            default:              sample_on_trail = 1'b0;
        endcase
    end

    // The first bit is already on MOSI before edge 1, so the shift on the opposite edge skips one end
    assign shift_tx  = sample_on_trail ? (lead_tick && !first_edge) : (trail_tick && !last_edge);
    assign sample_rx = sample_on_trail ? trail_tick : lead_tick;

    // While idle MOSI follows the live bit order so the first bit is valid as soon as data is loaded
    assign mosi_lsb = spi_ready ? spi_lsb_first : cfg.lsb_first;
    assign spi_mosi = mosi_lsb ? tx_sr[0] : tx_sr[DATA_WIDTH-1];

    // Transfer sequencing: alternate LEAD/TRAIL on each divider tick until the last edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (spi_start) begin
                        state    <= ST_LEAD;
                        edge_cnt <= '0;
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        state    <= ST_TRAIL;
                        edge_cnt <= edge_num;
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        edge_cnt <= edge_num;
                        state    <= last_edge ? ST_DONE : ST_LEAD;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // SCK idles at the registered CPOL and toggles once per divider tick while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_sck <= 1'b0;
        end else if (state == ST_IDLE) begin
            spi_sck <= spi_cpol;
        end else if (lead_tick || trail_tick) begin
            spi_sck <= ~spi_sck;
        end else if (state == ST_DONE) begin
            spi_sck <= cfg.cpol;
        end
    end

    // Latch the transfer configuration at the accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg     <= SPI_CFG_RESET;
            cfg_div <= '0;
        end else if (accept) begin
            cfg     <= '{cpol: spi_cpol, cpha: spi_cpha, lsb_first: spi_lsb_first};
            cfg_div <= spi_clk_div;
        end
    end

    // Transmit shift register: loads only while idle, shifts on the non-sampling edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sr <= '0;
        end else if (spi_ready && spi_tx_data_vld) begin
            tx_sr <= spi_tx_data;
        end else if (shift_tx) begin
            tx_sr <= shift_out(tx_sr, cfg.lsb_first);
        end
    end

    // Receive shadow register collects MISO on the sampling edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sr <= '0;
        end else if (sample_rx) begin
            rx_sr <= shift_in(rx_sr, spi_miso, cfg.lsb_first);
        end
    end

    // Publish the received word and pulse valid only when a transfer completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_rx_data <= '0;
            spi_rx_vld  <= 1'b0;
        end else begin
            spi_rx_vld <= (state == ST_DONE);
            if (state == ST_DONE) begin
                spi_rx_data <= rx_sr;
            end
        end
    end

    // Decode a chip-select write: out-of-range index or disable deselects everything
    always_comb begin
        ss_next = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (spi_enable && (32'(spi_cs_sel) == i)) begin
                ss_next[i] = 1'b0;
            end
        end
    end

    // Chip selects change only on a write strobe while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_ss <= '1;
        end else if (spi_ready && spi_enable_vld) begin
            spi_ss <= ss_next;
        end
    end

endmodule

// File: tb/tb_tk1_spi_master_param.sv
// Directed bench for tk1_spi_master_param (DATA_WIDTH=8, NUM_CS=4, DIV_WIDTH=8).
module tb_tk1_spi_master_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] spi_ss;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_enable;
    logic       spi_enable_vld;
    logic [2:0] spi_cs_sel;
    logic       spi_cpol;
    logic       spi_cpha;
    logic       spi_lsb_first;
    logic [7:0] spi_clk_div;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       spi_tx_data_vld;
    logic [7:0] spi_rx_data;
    logic       spi_rx_vld;
    logic       spi_ready;

    int checks = 0;
    int errors = 0;

    // Results of the last run_xfer
    int         n_edges;
    int         edge_cyc[64];
    logic [7:0] mosi_bits;
    int         mosi_cnt;
    int         ready_cyc;
    int         vld_cnt;
    int         vld_cyc;
    logic       first_level;
    logic       ready0;

    tk1_spi_master_param #(
        .DATA_WIDTH (8),
        .NUM_CS     (4),
        .DIV_WIDTH  (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_ss          (spi_ss),
        .spi_sck         (spi_sck),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .spi_enable      (spi_enable),
        .spi_enable_vld  (spi_enable_vld),
        .spi_cs_sel      (spi_cs_sel),
        .spi_cpol        (spi_cpol),
        .spi_cpha        (spi_cpha),
        .spi_lsb_first   (spi_lsb_first),
        .spi_clk_div     (spi_clk_div),
        .spi_start       (spi_start),
        .spi_tx_data     (spi_tx_data),
        .spi_tx_data_vld (spi_tx_data_vld),
        .spi_rx_data     (spi_rx_data),
        .spi_rx_vld      (spi_rx_vld),
        .spi_ready       (spi_ready)
    );

    always #5 clk = ~clk;

    function automatic logic slave_bit(input logic [7:0] w, input logic lsb, input int i);
        return lsb ? w[i] : w[7-i];
    endfunction

    // One transfer with a behavioural slave; cycle j=0 is the negedge right after the start edge.
    task automatic run_xfer(input logic cpol, input logic cpha, input logic lsb, input int div,
                            input logic [7:0] tx, input logic [7:0] slv,
                            input bit disturb, input int abort_edge);
        int   j;
        int   sidx;
        int   budget;
        logic prev_sck;
        @(negedge clk);
        spi_cpol = cpol; spi_cpha = cpha; spi_lsb_first = lsb;
        spi_clk_div = div[7:0]; spi_tx_data = tx; spi_tx_data_vld = 1'b1;
        sidx = 0;
        spi_miso = cpha ? 1'b0 : slave_bit(slv, lsb, 0);
        spi_start = 1'b1;
        n_edges = 0; mosi_cnt = 0; mosi_bits = '0; ready_cyc = -1;
        vld_cnt = 0; vld_cyc = -1; first_level = 1'bx;
        @(negedge clk);
        j = 0;
        spi_start = 1'b0; spi_tx_data_vld = 1'b0;
        ready0 = spi_ready;
        prev_sck = spi_sck;
        budget = 16 * (div + 1) + 8;
        while (j < budget) begin
            @(negedge clk);
            j++;
            if (spi_rx_vld) begin
                vld_cnt++;
                if (vld_cyc < 0) vld_cyc = j;
            end
            if (spi_ready && ready_cyc < 0) ready_cyc = j;
            if (!spi_ready && (spi_sck !== prev_sck)) begin
                n_edges++;
                if (n_edges <= 64) edge_cyc[n_edges-1] = j;
                if (n_edges == 1) first_level = spi_sck;
                if (((n_edges % 2) == 1) == !cpha) begin
                    if (mosi_cnt < 8) mosi_bits[7-mosi_cnt] = spi_mosi;
                    mosi_cnt++;
                end
                if (!cpha && (n_edges % 2) == 0) begin
                    sidx++;
                    if (sidx < 8) spi_miso = slave_bit(slv, lsb, sidx);
                end
                if (cpha && (n_edges % 2) == 1) begin
                    if (sidx < 8) spi_miso = slave_bit(slv, lsb, sidx);
                    sidx++;
                end
                if (abort_edge != 0 && n_edges == abort_edge) begin
                    reset = 1'b1;
                    #1;
                    return;
                end
            end
            prev_sck = spi_sck;
            if (disturb && j == 5) begin
                spi_start = 1'b1; spi_tx_data = ~tx; spi_tx_data_vld = 1'b1;
                spi_cpol = ~cpol; spi_enable = 1'b1; spi_cs_sel = 3'd3; spi_enable_vld = 1'b1;
            end else if (disturb && j == 6) begin
                spi_start = 1'b0; spi_tx_data_vld = 1'b0; spi_enable_vld = 1'b0;
            end
            if (ready_cyc >= 0 && j >= ready_cyc + 4) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spi_miso = 0; spi_enable = 0; spi_enable_vld = 0; spi_cs_sel = 0;
        spi_cpol = 0; spi_cpha = 0; spi_lsb_first = 0; spi_clk_div = 0;
        spi_start = 0; spi_tx_data = 0; spi_tx_data_vld = 0;
        #1;
        checks++; if (spi_ss !== 4'b1111) begin errors++; $display("FAIL reset_ss: got %b expected 1111", spi_ss); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", spi_sck); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
        checks++; if (spi_rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", spi_rx_data); end
        checks++; if (spi_rx_vld !== 1'b0) begin errors++; $display("FAIL reset_rx_vld: got %b expected 0", spi_rx_vld); end
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", spi_ready); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", spi_ready); end
    endtask

    task automatic test_mode0();
        run_xfer(1'b0, 1'b0, 1'b0, 0, 8'hA5, 8'h3C, 1'b0, 0);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL m0_ready_drop: got %b expected 0", ready0); end
        checks++; if (n_edges != 16) begin errors++; $display("FAIL m0_edges: got %0d expected 16", n_edges); end
        for (int k = 1; k <= 16 && k <= n_edges; k++) begin
            checks++; if (edge_cyc[k-1] != k) begin errors++; $display("FAIL m0_edge%0d_cycle: got %0d expected %0d", k, edge_cyc[k-1], k); end
        end
        checks++; if (first_level !== 1'b1) begin errors++; $display("FAIL m0_first_edge_rising: got %b expected 1", first_level); end
        checks++; if (mosi_bits !== 8'b1010_0101) begin errors++; $display("FAIL m0_mosi_seq: got %b expected 10100101", mosi_bits); end
        checks++; if (ready_cyc != 17) begin errors++; $display("FAIL m0_ready_cycle: got %0d expected 17", ready_cyc); end
        checks++; if (vld_cnt != 1 || vld_cyc != 17) begin errors++; $display("FAIL m0_rx_vld: got %0d pulses at %0d expected 1 at 17", vld_cnt, vld_cyc); end
        checks++; if (spi_rx_data !== 8'h3C) begin errors++; $display("FAIL m0_rx_data: got %h expected 3c", spi_rx_data); end
    endtask

    task automatic test_mode3();
        @(negedge clk);
        spi_cpol = 1'b1;
        #1;
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL idle_sck_registered: got %b expected 0", spi_sck); end
        @(negedge clk);
        checks++; if (spi_sck !== 1'b1) begin errors++; $display("FAIL idle_sck_cpol1: got %b expected 1", spi_sck); end
        run_xfer(1'b1, 1'b1, 1'b1, 3, 8'h01, 8'h96, 1'b0, 0);
        checks++; if (n_edges != 16) begin errors++; $display("FAIL m3_edges: got %0d expected 16", n_edges); end
        for (int k = 1; k <= 16 && k <= n_edges; k++) begin
            checks++; if (edge_cyc[k-1] != 4 * k) begin errors++; $display("FAIL m3_edge%0d_cycle: got %0d expected %0d", k, edge_cyc[k-1], 4 * k); end
        end
        checks++; if (first_level !== 1'b0) begin errors++; $display("FAIL m3_first_edge_falling: got %b expected 0", first_level); end
        checks++; if (mosi_bits !== 8'b1000_0000) begin errors++; $display("FAIL m3_mosi_seq: got %b expected 10000000", mosi_bits); end
        checks++; if (ready_cyc != 65) begin errors++; $display("FAIL m3_ready_cycle: got %0d expected 65", ready_cyc); end
        checks++; if (spi_rx_data !== 8'h96) begin errors++; $display("FAIL m3_rx_data: got %h expected 96", spi_rx_data); end
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL m3_rx_vld_count: got %0d expected 1", vld_cnt); end
        spi_cpol = 1'b0; spi_lsb_first = 1'b0; spi_cpha = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cs();
        @(negedge clk); spi_enable = 1'b1; spi_cs_sel = 3'd2; spi_enable_vld = 1'b1;
        @(negedge clk); spi_enable_vld = 1'b0;
        checks++; if (spi_ss !== 4'b1011) begin errors++; $display("FAIL cs_sel2: got %b expected 1011", spi_ss); end
        @(negedge clk); spi_cs_sel = 3'd5; spi_enable_vld = 1'b1;
        @(negedge clk); spi_enable_vld = 1'b0;
        checks++; if (spi_ss !== 4'b1111) begin errors++; $display("FAIL cs_sel5: got %b expected 1111", spi_ss); end
        @(negedge clk); spi_cs_sel = 3'd0; spi_enable_vld = 1'b1;
        @(negedge clk); spi_enable_vld = 1'b0;
        checks++; if (spi_ss !== 4'b1110) begin errors++; $display("FAIL cs_sel0: got %b expected 1110", spi_ss); end
        @(negedge clk); spi_enable = 1'b0; spi_cs_sel = 3'd1; spi_enable_vld = 1'b1;
        @(negedge clk); spi_enable_vld = 1'b0;
        checks++; if (spi_ss !== 4'b1111) begin errors++; $display("FAIL cs_disable: got %b expected 1111", spi_ss); end
        @(negedge clk); spi_enable = 1'b1; spi_cs_sel = 3'd0; spi_enable_vld = 1'b1;
        @(negedge clk); spi_enable_vld = 1'b0;
    endtask

    task automatic test_busy_ignore();
        run_xfer(1'b0, 1'b0, 1'b0, 1, 8'hC3, 8'h5A, 1'b1, 0);
        checks++; if (n_edges != 16) begin errors++; $display("FAIL busy_edges: got %0d expected 16", n_edges); end
        checks++; if (n_edges >= 16 && edge_cyc[15] != 32) begin errors++; $display("FAIL busy_last_edge_cycle: got %0d expected 32", edge_cyc[15]); end
        checks++; if (first_level !== 1'b1) begin errors++; $display("FAIL busy_cpol_kept: got %b expected 1", first_level); end
        checks++; if (mosi_bits !== 8'hC3) begin errors++; $display("FAIL busy_mosi_seq: got %h expected c3", mosi_bits); end
        checks++; if (spi_rx_data !== 8'h5A) begin errors++; $display("FAIL busy_rx_data: got %h expected 5a", spi_rx_data); end
        checks++; if (ready_cyc != 33) begin errors++; $display("FAIL busy_ready_cycle: got %0d expected 33", ready_cyc); end
        checks++; if (vld_cnt != 1) begin errors++; $display("FAIL busy_rx_vld_once: got %0d expected 1", vld_cnt); end
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL busy_no_queued_start: got %b expected 1", spi_ready); end
        checks++; if (spi_ss !== 4'b1110) begin errors++; $display("FAIL busy_ss_unchanged: got %b expected 1110", spi_ss); end
        spi_cpol = 1'b0; spi_enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int bad;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        run_xfer(1'b0, 1'b0, 1'b0, 0, 8'hA5, 8'h3C, 1'b0, 7);
        checks++; if (reset !== 1'b1 || n_edges != 7) begin errors++; $display("FAIL abort_reached_edge7: got %0d edges expected 7", n_edges); end
        checks++; if (spi_ss !== 4'b1111) begin errors++; $display("FAIL abort_ss: got %b expected 1111", spi_ss); end
        checks++; if (spi_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", spi_ready); end
        checks++; if (spi_rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_data: got %h expected 00", spi_rx_data); end
        checks++; if (spi_rx_vld !== 1'b0 || vld_cnt != 0) begin errors++; $display("FAIL abort_rx_vld: got %0d pulses expected 0", vld_cnt); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b expected 0", spi_sck); end
        @(negedge clk); reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (spi_ready !== 1'b1 || spi_sck !== 1'b0 || spi_rx_vld !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_stays_idle: got %0d busy cycles expected 0", bad); end
    endtask

    task automatic test_mode1();
        run_xfer(1'b0, 1'b1, 1'b0, 2, 8'h5A, 8'hC3, 1'b0, 0);
        checks++; if (n_edges >= 1 && edge_cyc[0] != 3) begin errors++; $display("FAIL m1_first_edge_cycle: got %0d expected 3", edge_cyc[0]); end
        checks++; if (n_edges != 16) begin errors++; $display("FAIL m1_edges: got %0d expected 16", n_edges); end
        checks++; if (mosi_bits !== 8'h5A) begin errors++; $display("FAIL m1_mosi_seq: got %h expected 5a", mosi_bits); end
        checks++; if (spi_rx_data !== 8'hC3) begin errors++; $display("FAIL m1_rx_data: got %h expected c3", spi_rx_data); end
        checks++; if (ready_cyc != 49) begin errors++; $display("FAIL m1_ready_cycle: got %0d expected 49", ready_cyc); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_cs();
        test_busy_ignore();
        test_reset_abort();
        test_mode1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tk1_spi_master_param.md
TK1_SPI_MASTER_PARAM -- requirements
Module: tk1_spi_master_param

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 8, bits per transfer word (2..32).
- NUM_CS, 1, number of active-low chip selects (1..8).
- DIV_WIDTH, 8, width of the SCK half-period divider.
REQ-002 Ports SHALL be:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset; one clock domain only.
- spi_ss  out  NUM_CS  chip selects, active low.
- spi_sck  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.
- spi_enable  in  1  assert selected chip select.
- spi_enable_vld  in  1  write strobe for spi_enable/spi_cs_sel.
- spi_cs_sel  in  3  index of the chip select to drive.
- spi_cpol  in  1  SCK idle level.
- spi_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- spi_lsb_first  in  1  shift order.
- spi_clk_div  in  DIV_WIDTH  half-period = spi_clk_div+1 clk cycles.
- spi_start  in  1  start one word transfer.
- spi_tx_data  in  DATA_WIDTH  word to send.
- spi_tx_data_vld  in  1  load spi_tx_data.
- spi_rx_data  out  DATA_WIDTH  last completed received word.
- spi_rx_vld  out  1  one-cycle pulse: spi_rx_data updated.
- spi_ready  out  1  idle, accepts start/load/cs writes.

Function
REQ-003 FSM states SHALL be IDLE, LEAD, TRAIL, DONE; IDLE->LEAD on spi_start && spi_ready; LEAD->TRAIL and TRAIL->LEAD on divider expiry, producing one SCK edge each; TRAIL->DONE after edge 2*DATA_WIDTH; DONE->IDLE unconditionally.
REQ-004 spi_cpol, spi_cpha, spi_lsb_first and spi_clk_div SHALL be captured at the accepted start; changes mid-transfer SHALL have no effect on that transfer.
REQ-005 In IDLE, spi_sck SHALL equal the registered spi_cpol, updated one cycle after spi_cpol changes.
REQ-006 With D = captured divider, SCK edge k (k = 1..2*DATA_WIDTH) SHALL appear k*(D+1) cycles after the start cycle.
REQ-007 spi_ready SHALL drop the cycle after an accepted start; spi_ready and spi_rx_vld SHALL assert one cycle after edge 2*DATA_WIDTH.
REQ-008 spi_tx_data_vld SHALL load the tx shift register only while spi_ready=1; it SHALL be ignored while busy. If spi_tx_data_vld and spi_start occur in the same cycle, the load SHALL be used by that transfer.
REQ-009 spi_mosi SHALL present the MSB (or LSB if spi_lsb_first) of the tx register at all times.
REQ-010 Shifting SHALL occur as follows:
- CPHA=0: shift on every trailing edge except the last.
- CPHA=1: shift on every leading edge except the first.
REQ-011 spi_miso SHALL be sampled into a shadow shift register on leading edges (CPHA=0) or trailing edges (CPHA=1), in the captured bit order.
REQ-012 spi_rx_data SHALL change only at completion; it SHALL hold its value across chip select changes and new loads.
REQ-013 On spi_enable_vld while spi_ready=1, spi_ss SHALL be set as follows:
- spi_enable=1 and spi_cs_sel<NUM_CS: that bit low, all others high.
- Otherwise: all bits high.
REQ-014 spi_enable_vld while busy SHALL be ignored.
REQ-015 spi_start while busy SHALL be ignored and SHALL NOT be queued.
REQ-016 The divider counter SHALL count from 0 to D and reload; D=0 SHALL give one SCK edge per clk cycle.

Reset
REQ-017 On reset assertion, all outputs SHALL take these values immediately (asynchronously):
- spi_ss all ones.
- spi_sck 0.
- spi_mosi 0.
- spi_rx_data 0.
- spi_rx_vld 0.
- spi_ready 1.
- FSM in IDLE.
- Captured configuration all zero.
REQ-018 Reset mid-transfer SHALL abort the transfer without updating spi_rx_data or pulsing spi_rx_vld.
REQ-019 Reset deassertion SHALL be synchronised by the instantiating level; the block SHALL leave IDLE only on an explicit start.

Structure
REQ-020 Package tk1_spi_pkg SHALL hold the FSM state encoding, the CPOL/CPHA mode constants, and the default parameter values.
REQ-021 The half-period counter SHALL be the sub-module tk1_spi_clk_div, with inputs load, div and outputs tick.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Mode 0, D=0, W=8, tx 0xA5, slave returns 0x3C: 16 SCK edges one cycle apart, MOSI 1,0,1,0,0,1,0,1, rx_data=0x3C, ready at start+17.
- Mode 3, D=3, lsb_first=1, tx 0x01: SCK idles high, first edge at start+4, MOSI LSB first, ready at start+65.
- NUM_CS=4: enable_vld with cs_sel=2 -> ss=4'b1011; cs_sel=5 -> ss=4'b1111; enable_vld while busy -> ss unchanged.
- Start, tx load and cpol change while busy: all ignored; current word completes unchanged; rx_vld pulses exactly once.
- Reset asserted at edge 7 of a transfer: ss=all ones, ready=1 and rx_data keeps its pre-transfer value, all within the same cycle.
